// File: rtl/gray_counter_param_pkg.sv
// Shared constants and types for the parametrised Gray counter family.
// SAT_MODE selects whether the counter wraps or holds at its terminal value.
package gray_counter_param_pkg;

  localparam int unsigned GRAY_MODE_WRAP = 0;
  localparam int unsigned GRAY_MODE_SAT  = 1;

  // Classification of what the counter does on a given edge.
  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_LOAD,
    STEP_COUNT,
    STEP_TERMINAL
  } step_e;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits from the MSB down to that position.
module gray2bin #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  logic acc;

  always_comb begin
    bin = '0;
    acc = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      acc                = acc ^ gray[WIDTH-1-i];
      bin[WIDTH-1-i]     = acc;
    end
  end

endmodule

// File: rtl/gray_counter_param.sv
// N-bit up/down counter with registered Gray and binary outputs, Gray-coded
// parallel load, wrap/saturate terminal handling, sticky flags and carry pulse.
module gray_counter_param
  import gray_counter_param_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned SAT_MODE = GRAY_MODE_WRAP
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadGray,
  input  logic             ClrFlags,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Carry
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam bit               SAT = (SAT_MODE == GRAY_MODE_SAT);

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             up_term;
  logic             dn_term;
  step_e            step;

  gray2bin #(
    .WIDTH(WIDTH)
  ) u_load_g2b (
    .gray(LoadGray),
    .bin (load_bin)
  );

  always_comb begin
    step      = STEP_HOLD;
    next_bin  = Binary;
    next_gray = Output;
    up_term   = 1'b0;
    dn_term   = 1'b0;
    if (Load) begin
      step      = STEP_LOAD;
      next_bin  = load_bin;
      next_gray = LoadGray;
    end else if (En) begin
      if (Dir && (Binary == MAX)) begin
        step     = STEP_TERMINAL;
        up_term  = 1'b1;
        next_bin = SAT ? MAX : '0;
      end else if (!Dir && (Binary == '0)) begin
        step     = STEP_TERMINAL;
        dn_term  = 1'b1;
        next_bin = SAT ? '0 : MAX;
      end else begin
        step     = STEP_COUNT;
        next_bin = Dir ? (Binary + 1'b1) : (Binary - 1'b1);
      end
      // Gray is encoded from the next binary value so Output is a pure register.
      next_gray = next_bin ^ (next_bin >> 1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Binary    <= '0;
      Output    <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Carry     <= 1'b0;
    end else begin
      Binary    <= next_bin;
      Output    <= next_gray;
      Carry     <= (step == STEP_TERMINAL);
      // A terminal event in the same cycle as ClrFlags keeps its flag set.
      Overflow  <= up_term | (Overflow  & ~ClrFlags);
      Underflow <= dn_term | (Underflow & ~ClrFlags);
    end
  end

endmodule

// File: tb/tb_gray_counter_param.sv
// Bench for gray_counter_param: three instances (3-bit wrap, 4-bit wrap,
// 3-bit saturate) share stimulus and are checked against an arithmetic model.
module tb_gray_counter_param;

  logic       clk = 1'b0;
  logic       rst, en, dir, load, clr;
  logic [3:0] lg;

  logic [2:0] g0, b0, g2, b2;
  logic [3:0] g1, b1;
  logic       o0, u0, c0, o1, u1, c1, o2, u2, c2;

  always #5 clk = ~clk;

  gray_counter_param #(.WIDTH(3), .SAT_MODE(0)) dut_w3 (
    .Clk(clk), .Reset(rst), .En(en), .Dir(dir), .Load(load), .LoadGray(lg[2:0]),
    .ClrFlags(clr), .Output(g0), .Binary(b0), .Overflow(o0), .Underflow(u0), .Carry(c0));
  gray_counter_param #(.WIDTH(4), .SAT_MODE(0)) dut_w4 (
    .Clk(clk), .Reset(rst), .En(en), .Dir(dir), .Load(load), .LoadGray(lg),
    .ClrFlags(clr), .Output(g1), .Binary(b1), .Overflow(o1), .Underflow(u1), .Carry(c1));
  gray_counter_param #(.WIDTH(3), .SAT_MODE(1)) dut_sat (
    .Clk(clk), .Reset(rst), .En(en), .Dir(dir), .Load(load), .LoadGray(lg[2:0]),
    .ClrFlags(clr), .Output(g2), .Binary(b2), .Overflow(o2), .Underflow(u2), .Carry(c2));

  int checks = 0;
  int errors = 0;

  // Reference model state, one entry per instance.
  int w   [3] = '{3, 4, 3};
  int sat [3] = '{0, 0, 1};
  int m_bin [3], m_gray [3], m_ovf [3], m_unf [3], m_car [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int g2b(input int g, input int width);
    for (int b = 0; b < (1 << width); b++)
      if ((b ^ (b >> 1)) == g) return b;
    return -1;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int lim;
      bit up_t, dn_t;
      lim  = (1 << w[k]) - 1;
      up_t = 0;
      dn_t = 0;
      if (rst) begin
        m_bin[k] = 0; m_gray[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_car[k] = 0;
      end else begin
        if (load) begin
          m_gray[k] = int'(lg) & lim;
          m_bin[k]  = g2b(m_gray[k], w[k]);
        end else if (en) begin
          if (dir) begin
            if (m_bin[k] == lim) begin up_t = 1; m_bin[k] = sat[k] ? lim : 0; end
            else m_bin[k] = m_bin[k] + 1;
          end else begin
            if (m_bin[k] == 0) begin dn_t = 1; m_bin[k] = sat[k] ? 0 : lim; end
            else m_bin[k] = m_bin[k] - 1;
          end
          m_gray[k] = m_bin[k] ^ (m_bin[k] >> 1);
        end
        m_car[k] = int'(up_t | dn_t);
        m_ovf[k] = (up_t || (m_ovf[k] != 0 && !clr)) ? 1 : 0;
        m_unf[k] = (dn_t || (m_unf[k] != 0 && !clr)) ? 1 : 0;
      end
    end
  endtask

  task automatic compare_model();
    logic [3:0] gv [3], bv [3];
    logic       ov [3], uv [3], cv [3];
    gv = '{{1'b0, g0}, g1, {1'b0, g2}};
    bv = '{{1'b0, b0}, b1, {1'b0, b2}};
    ov = '{o0, o1, o2};
    uv = '{u0, u1, u2};
    cv = '{c0, c1, c2};
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_bin%0d", k),  {28'd0, bv[k]}, m_bin[k]);
      chk($sformatf("model_gray%0d", k), {28'd0, gv[k]}, m_gray[k]);
      chk($sformatf("model_ovf%0d", k),  {31'd0, ov[k]}, m_ovf[k]);
      chk($sformatf("model_unf%0d", k),  {31'd0, uv[k]}, m_unf[k]);
      chk($sformatf("model_car%0d", k),  {31'd0, cv[k]}, m_car[k]);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic d, input logic l,
                       input logic [3:0] g, input logic c);
    rst = r; en = e; dir = d; load = l; lg = g; clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  typedef struct {
    logic       rst, en, dir;
    logic [2:0] gray;
    logic [2:0] bin;
    logic       car, ovf, unf;
  } vec_t;

  vec_t tbl [11];
  logic [3:0] prev;
  logic [2:0] exp_b [5];
  logic       exp_c [5];

  initial begin
    drive(1, 0, 1, 0, 4'd0, 0);

    // Plan 1: 3-bit wrap up-count from reset.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 3'b001, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 3'b011, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 3'b010, 3'd3, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 3'b110, 3'd4, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 3'b111, 3'd5, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 3'b101, 3'd6, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 3'b100, 3'd7, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 3'b000, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 3'b001, 3'd1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 3'b011, 3'd2, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].dir, 0, 4'd0, 0);
      tick();
      chk($sformatf("p1_gray[%0d]", i), {29'd0, g0}, {29'd0, tbl[i].gray});
      chk($sformatf("p1_bin[%0d]", i),  {29'd0, b0}, {29'd0, tbl[i].bin});
      chk($sformatf("p1_car[%0d]", i),  {31'd0, c0}, {31'd0, tbl[i].car});
      chk($sformatf("p1_ovf[%0d]", i),  {31'd0, o0}, {31'd0, tbl[i].ovf});
      chk($sformatf("p1_unf[%0d]", i),  {31'd0, u0}, {31'd0, tbl[i].unf});
    end

    // Plan 2: 4-bit load zero, count down through the wrap.
    drive(1, 0, 0, 0, 4'd0, 0); tick();
    drive(0, 0, 0, 1, 4'd0, 0); tick();
    drive(0, 1, 0, 0, 4'd0, 0); tick();
    chk("p2_bin",  {28'd0, b1}, 32'd15);
    chk("p2_gray", {28'd0, g1}, 32'h8);
    chk("p2_unf",  {31'd0, u1}, 32'd1);
    chk("p2_car",  {31'd0, c1}, 32'd1);
    prev = g1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("p2_onebit[%0d]", i), $countones(prev ^ g1), 32'd1);
      if (i == 0) chk("p2_car_drop", {31'd0, c1}, 32'd0);
      prev = g1;
    end

    // Plan 3: 3-bit saturate up from 5, then step back down.
    exp_b = '{3'd6, 3'd7, 3'd7, 3'd7, 3'd7};
    exp_c = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    drive(1, 0, 1, 0, 4'd0, 0); tick();
    drive(0, 0, 1, 1, 4'b0111, 0); tick();
    chk("p3_load_bin", {29'd0, b2}, 32'd5);
    drive(0, 1, 1, 0, 4'd0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("p3_bin[%0d]", i), {29'd0, b2}, {29'd0, exp_b[i]});
      chk($sformatf("p3_car[%0d]", i), {31'd0, c2}, {31'd0, exp_c[i]});
    end
    chk("p3_ovf", {31'd0, o2}, 32'd1);
    drive(0, 1, 0, 0, 4'd0, 0); tick();
    chk("p3_down_bin", {29'd0, b2}, 32'd6);
    chk("p3_down_car", {31'd0, c2}, 32'd0);

    // Plan 4: ClrFlags coinciding with an up-wrap keeps Overflow.
    drive(1, 0, 1, 0, 4'd0, 0); tick();
    drive(0, 0, 1, 1, 4'b0100, 0); tick();
    drive(0, 1, 1, 0, 4'd0, 0); tick();
    chk("p4_ovf_set", {31'd0, o0}, 32'd1);
    drive(0, 0, 1, 1, 4'b0100, 0); tick();
    drive(0, 1, 1, 0, 4'd0, 1); tick();
    chk("p4_ovf_kept", {31'd0, o0}, 32'd1);
    chk("p4_bin_wrap", {29'd0, b0}, 32'd0);
    drive(0, 0, 1, 0, 4'd0, 1); tick();
    chk("p4_ovf_clr", {31'd0, o0}, 32'd0);
    chk("p4_unf_clr", {31'd0, u0}, 32'd0);

    // Plan 5: Load beats En; Reset beats Load.
    drive(0, 1, 1, 1, 4'b0110, 0); tick();
    chk("p5_load_bin",  {29'd0, b0}, 32'd4);
    chk("p5_load_gray", {29'd0, g0}, 32'h6);
    drive(1, 1, 1, 1, 4'b0110, 0); tick();
    chk("p5_rst_bin",  {29'd0, b0}, 32'd0);
    chk("p5_rst_gray", {29'd0, g0}, 32'd0);
    chk("p5_rst_flags", {29'd0, o0, u0, c0}, 32'd0);

    // Plan 6: Dir toggling every cycle from 3.
    drive(0, 0, 1, 1, 4'b0010, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, (i % 2 == 0), 0, 4'd0, 0); tick();
      chk($sformatf("p6_bin[%0d]", i), {29'd0, b0}, (i % 2 == 0) ? 32'd4 : 32'd3);
      chk($sformatf("p6_flags[%0d]", i), {29'd0, o0, u0, c0}, 32'd0);
    end

    // Randomised traffic; dir changes rarely so terminals are reached often.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0) ? ~dir : dir, ($urandom_range(0, 11) == 0),
            4'($urandom), ($urandom_range(0, 15) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_counter_param.md
Name: gray_counter_param

Overview:
Parametrised successor to the team's 3-bit Gray counter. An N-bit up/down counter that presents its value in Gray code, registered and glitch-free, for clock-domain-crossing pointers and encoder outputs. Adds:
- direction control
- parallel load, supplied in Gray code
- wrap or saturate terminal behaviour
- separate sticky Overflow and Underflow flags with an explicit clear
- a one-cycle Carry pulse

Parameters:
WIDTH, 3, counter width in bits, minimum 2.
SAT_MODE, 0, 0 = wrap at the terminal value, 1 = saturate (hold) at the terminal value.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
En  input  1  count enable.
Dir  input  1  count direction: 1 = up, 0 = down.
Load  input  1  parallel-load strobe.
LoadGray  input  WIDTH  load value, Gray-coded.
ClrFlags  input  1  clears Overflow and Underflow.
Output  output  WIDTH  registered Gray-coded count.
Binary  output  WIDTH  registered binary count.
Overflow  output  1  sticky flag: an up-count hit the terminal value.
Underflow  output  1  sticky flag: a down-count hit the terminal value.
Carry  output  1  one-cycle pulse on the cycle after a terminal event.

Behaviour:
- Clk is the single clock. Reset is synchronous and active-high. Initial values equal the reset values.
- Reset values: Binary=0, Output=0, Overflow=0, Underflow=0, Carry=0.
- Priority each edge: Reset > Load > En. ClrFlags is independent of this priority, except that Reset already clears the flags.
- Load:
  - binary <= gray2bin(LoadGray); Output <= LoadGray.
  - Carry <= 0. Sticky flags unchanged (ClrFlags still applies).
  - En is ignored that cycle.
- Count (En=1, Load=0):
  - Up from MAX = 2^WIDTH-1 is a terminal event.
    - Wrap mode: next = 0.
    - Saturate mode: next = MAX (held).
  - Down from 0 is a terminal event.
    - Wrap mode: next = MAX.
    - Saturate mode: next = 0.
  - Otherwise next = binary ± 1.
  - All arithmetic is modulo 2^WIDTH. No WIDTH+1 comparison.
- Latency: Output and Binary reflect the new value one edge after the command.
  - Output is always registered as next ^ (next >> 1). It is never derived combinationally from Binary.
- Carry <= 1 for exactly one cycle after each terminal event, otherwise 0.
  - In saturate mode, Carry pulses on every enabled cycle spent pushing against the limit.
- Overflow sets on an up terminal event. Underflow sets on a down terminal event. Both remain set until Reset or ClrFlags.
- ClrFlags in the same cycle as a terminal event: the set wins, so the event is never lost. The other flag is cleared.
- En=0 and Load=0: all state holds, and Carry <= 0.
- Dir may change on any cycle. It takes effect on the next enabled edge with no dead cycle.
- Reset asserted mid-count or during Load: the next edge forces the reset values regardless of the other inputs.
- Successive Output values differ in exactly one bit for every ±1 step, including wrap. Load and saturate-hold are exempt.

Decomposition:
- Shared constants include: GRAY_MODE_WRAP=0, GRAY_MODE_SAT=1.
- One sub-module, gray2bin: parametrised by WIDTH, purely combinational, prefix-XOR from the MSB down. It is instantiated for LoadGray and reused by the team's other Gray-code blocks.
- bin-to-Gray is a single expression inside the counter and needs no module.

Test Plan:
1. WIDTH=3, SAT_MODE=0, Dir=1, En=1 for 10 cycles from Reset → Output sequence 000,001,011,010,110,111,101,100,000,001.
   - Carry high on exactly the cycle after 100→000.
   - Overflow=1 from that edge on; Underflow=0.
2. WIDTH=4, SAT_MODE=0, Load with LoadGray=4'b0000, then Dir=0, En=1 → Binary=15, Output=4'b1000 after one edge.
   - Underflow=1, Carry=1 for one cycle.
   - Over 16 further edges, every Output change is a single-bit change.
3. WIDTH=3, SAT_MODE=1, count up from 5 with En held for 5 cycles → Binary 6, 7, 7, 7, 7.
   - Carry high on each of the last three cycles; Overflow=1.
   - Then Dir=0 → Binary 6, and Carry=0.
4. Overflow=1, then assert ClrFlags on the same edge as an up-wrap in wrap mode → Overflow stays 1.
   - Then ClrFlags alone → Overflow=0, Underflow=0.
5. Assert Load (LoadGray=3'b110) and En together, then Reset together with Load → first edge gives Binary=4, Output=110.
   - Next edge gives all outputs 0.
6. Dir toggled every cycle with En=1 from Binary=3 → Binary 4, 3, 4, 3, with no terminal events and flags unchanged.
